// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP pixel engine: bpp encodings, register map,
// pipeline control payload and the palette reset ramp.
package vdp_pkg;

  typedef enum logic [1:0] {
    BPP_8 = 2'd0,
    BPP_4 = 2'd1,
    BPP_2 = 2'd2,
    BPP_1 = 2'd3
  } bpp_e;

  localparam logic [2:0] REG_MODE    = 3'd0;
  localparam logic [2:0] REG_BASE_LO = 3'd1;
  localparam logic [2:0] REG_BASE_HI = 3'd2;
  localparam logic [2:0] REG_STRIDE  = 3'd3;
  localparam logic [2:0] REG_PAL_IDX = 3'd4;
  localparam logic [2:0] REG_PAL_GB  = 3'd5;
  localparam logic [2:0] REG_PAL_R   = 3'd6;

  localparam int unsigned PAL_N = 16;
  localparam int unsigned PAL_W = 12;

  // Field order matches the MODE register layout {vscale, hscale, bpp}
  typedef struct packed {
    logic [1:0] vscale;
    logic [1:0] hscale;
    bpp_e       bpp;
  } mode_t;

  // Per-pixel control carried alongside the memory access
  typedef struct packed {
    logic       vis;
    logic       hs;
    logic       vs;
    bpp_e       bpp;
    logic [2:0] sub;
  } pix_ctl_t;

  function automatic logic [PAL_W-1:0] pal_reset_entry(input logic [3:0] i);
    return {i, i, i};
  endfunction

endpackage

// File: rtl/vdp_palette.sv
// 16x12 palette with staged G/B write, auto-incrementing index and a
// registered read port that also forwards direct (8bpp) colour.
module vdp_palette
  import vdp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [2:0]       i_addr,
  input  logic [7:0]       i_data,
  input  logic             i_rd_vis,
  input  logic             i_rd_direct,
  input  logic [PAL_W-1:0] i_direct_rgb,
  input  logic [3:0]       i_rd_idx,
  output logic [PAL_W-1:0] o_rgb
);

  logic [PAL_W-1:0] r_pal [PAL_N];
  logic [3:0]       r_idx;
  logic [7:0]       r_stg;
  logic [PAL_W-1:0] r_rgb;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < PAL_N; i++) r_pal[i] <= pal_reset_entry(4'(i));
      r_idx <= 4'd0;
      r_stg <= 8'd0;
    end else if (i_we) begin
      case (i_addr)
        REG_PAL_IDX: r_idx <= i_data[3:0];
        REG_PAL_GB:  r_stg <= i_data;
        REG_PAL_R: begin
          r_pal[r_idx] <= {i_data[3:0], r_stg};
          r_idx        <= r_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Stage P: blanked pixels are forced to black
  always_ff @(posedge clk) begin
    if (!reset)         r_rgb <= '0;
    else if (!i_rd_vis) r_rgb <= '0;
    else                r_rgb <= i_rd_direct ? i_direct_rgb : r_pal[i_rd_idx];
  end

  assign o_rgb = r_rgb;

endmodule

// File: rtl/vdp_pixel_engine.sv
// Bitmap pixel engine: double-buffered mode/base/stride, scaled address
// generation, latency-matched decode and palette lookup to the RGB DAC.
module vdp_pixel_engine
  import vdp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned COL_W       = 10,
  parameter int unsigned LINE_W      = 10,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COL_W-1:0]  column,
  input  logic [LINE_W-1:0] line,
  input  logic              visible,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              reg_we,
  input  logic [2:0]        reg_addr,
  input  logic [7:0]        reg_data,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_in,
  output logic [3:0]        r,
  output logic [3:0]        g,
  output logic [3:0]        b,
  output logic              hsync,
  output logic              vsync
);

  mode_t             r_mode_sh, r_mode_act;
  logic [ADDR_W-1:0] r_base_sh, r_base_act;
  logic [7:0]        r_stride_sh, r_stride_act;
  logic              r_vs_prev;
  logic [15:0]       w_base_wr;

  always_comb begin
    w_base_wr = 16'(r_base_sh);
    if (reg_addr == REG_BASE_HI) w_base_wr[15:8] = reg_data;
    else                         w_base_wr[7:0]  = reg_data;
  end

  // Shadow registers; active copies swap in on the vsync rising edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mode_sh    <= '0;
      r_mode_act   <= '0;
      r_base_sh    <= '0;
      r_base_act   <= '0;
      r_stride_sh  <= 8'h80;
      r_stride_act <= 8'h80;
      r_vs_prev    <= 1'b0;
    end else begin
      r_vs_prev <= vsync_in;
      if (!r_vs_prev && vsync_in) begin
        r_mode_act   <= r_mode_sh;
        r_base_act   <= r_base_sh;
        r_stride_act <= r_stride_sh;
      end
      if (reg_we) begin
        case (reg_addr)
          REG_MODE:                 r_mode_sh   <= mode_t'(reg_data[5:0]);
          REG_BASE_LO, REG_BASE_HI: r_base_sh   <= ADDR_W'(w_base_wr);
          REG_STRIDE:               r_stride_sh <= reg_data;
          default: ;
        endcase
      end
    end
  end

  logic [COL_W-1:0]  w_px;
  logic [LINE_W-1:0] w_ln;
  logic [COL_W-1:0]  w_byte;
  logic [8:0]        w_stride;
  logic [2:0]        w_sub;
  logic [ADDR_W-1:0] w_addr;

  // Modular arithmetic in ADDR_W bits equals truncating the full-width sum
  assign w_px     = column >> r_mode_act.hscale;
  assign w_ln     = line >> r_mode_act.vscale;
  assign w_byte   = w_px >> r_mode_act.bpp;
  assign w_stride = (r_stride_act == 8'd0) ? 9'd256 : {1'b0, r_stride_act};
  assign w_sub    = 3'(w_px) & 3'((4'd1 << r_mode_act.bpp) - 4'd1);
  assign w_addr   = r_base_act + ADDR_W'(w_ln) * ADDR_W'(w_stride) + ADDR_W'(w_byte);

  logic [ADDR_W-1:0] r_addr;
  pix_ctl_t          r_a_ctl;

  // Stage A
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr  <= '0;
      r_a_ctl <= '0;
    end else begin
      r_addr  <= w_addr;
      r_a_ctl <= '{vis: visible, hs: hsync_in, vs: vsync_in, bpp: r_mode_act.bpp, sub: w_sub};
    end
  end

  assign addr = r_addr;

  for (genvar i = 0; i < MEM_LATENCY; i++) begin : g_dly
    pix_ctl_t r_q;
    if (i == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (!reset) r_q <= '0;
        else        r_q <= r_a_ctl;
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (!reset) r_q <= '0;
        else        r_q <= g_dly[i-1].r_q;
      end
    end
  end

  pix_ctl_t   w_d_ctl;
  logic [11:0] w_direct_rgb;
  logic [3:0]  w_idx;

  assign w_d_ctl      = g_dly[MEM_LATENCY-1].r_q;
  assign w_direct_rgb = {data_in[2:0], 1'b0, data_in[5:3], 1'b0, data_in[7:6], 2'b00};

  // Stage D: MSB-first field extraction
  always_comb begin
    w_idx = 4'd0;
    case (w_d_ctl.bpp)
      BPP_4:   w_idx = 4'(data_in >> {~w_d_ctl.sub[0], 2'b00});
      BPP_2:   w_idx = {2'b00, 2'(data_in >> {~w_d_ctl.sub[1:0], 1'b0})};
      BPP_1:   w_idx = {3'b000, 1'(data_in >> ~w_d_ctl.sub)};
      default: w_idx = 4'd0;
    endcase
  end

  logic [11:0] w_rgb;

  vdp_palette u_palette (
    .clk          (clk),
    .reset        (reset),
    .i_we         (reg_we),
    .i_addr       (reg_addr),
    .i_data       (reg_data),
    .i_rd_vis     (w_d_ctl.vis),
    .i_rd_direct  (w_d_ctl.bpp == BPP_8),
    .i_direct_rgb (w_direct_rgb),
    .i_rd_idx     (w_idx),
    .o_rgb        (w_rgb)
  );

  logic r_hs, r_vs;

  // Stage P syncs, aligned with the palette read register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hs <= 1'b0;
      r_vs <= 1'b0;
    end else begin
      r_hs <= w_d_ctl.hs;
      r_vs <= w_d_ctl.vs;
    end
  end

  assign r     = w_rgb[11:8];
  assign g     = w_rgb[7:4];
  assign b     = w_rgb[3:0];
  assign hsync = r_hs;
  assign vsync = r_vs;

endmodule

// File: tb/tb_vdp_pixel_engine.sv
// Bench for vdp_pixel_engine: four instances (MEM_LATENCY 1..4) share stimulus
// and are checked every cycle against a frame-level model plus fixed literals.
module tb_vdp_pixel_engine;

  localparam int NI = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [9:0] column, line;
  logic       visible, hsync_in, vsync_in, reg_we;
  logic [2:0] reg_addr;
  logic [7:0] reg_data;

  logic [15:0] o_addr [NI];
  logic [3:0]  o_r [NI];
  logic [3:0]  o_g [NI];
  logic [3:0]  o_b [NI];
  logic        o_hs [NI];
  logic        o_vs [NI];

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int unsigned LAT = k + 1;
    logic [15:0] ram_pipe [LAT];
    logic [7:0]  ram_q;

    // Model RAM: data = addr[7:0]^addr[15:8], LAT cycles after addr changes
    always @(posedge clk) begin
      ram_pipe[0] <= o_addr[k];
      for (int unsigned i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_q = ram_pipe[LAT-1][7:0] ^ ram_pipe[LAT-1][15:8];

    vdp_pixel_engine #(
      .ADDR_W(16), .COL_W(10), .LINE_W(10), .MEM_LATENCY(LAT)
    ) u_dut (
      .clk(clk), .reset(reset), .column(column), .line(line), .visible(visible),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .reg_we(reg_we), .reg_addr(reg_addr),
      .reg_data(reg_data), .addr(o_addr[k]), .data_in(ram_q), .r(o_r[k]), .g(o_g[k]),
      .b(o_b[k]), .hsync(o_hs[k]), .vsync(o_vs[k])
    );
  end

  // ---------------- behavioural model ----------------
  logic [5:0]  m_mode_sh, m_mode_act;
  logic [15:0] m_base_sh, m_base_act;
  logic [7:0]  m_stride_sh, m_stride_act;
  logic [11:0] m_pal [16];
  int          m_pal_idx;
  logic [7:0]  m_stg;
  logic        m_vs_prev;
  logic [13:0] h_val [64];
  bit          h_rst [64];
  logic [15:0] m_addr;
  int          n_edge = 0;
  bit          started = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic logic [27:0] model_px(input int c, input int l);
    int bpp, hsc, vsc, px, ln, stride, a, d, n, w, sub, idx;
    logic [11:0] rgb;
    bpp    = int'(m_mode_act[1:0]);
    hsc    = int'(m_mode_act[3:2]);
    vsc    = int'(m_mode_act[5:4]);
    px     = c >> hsc;
    ln     = l >> vsc;
    stride = (m_stride_act == 8'd0) ? 256 : int'(m_stride_act);
    a      = (int'(m_base_act) + ln * stride + (px >> bpp)) % 65536;
    d      = (a & 255) ^ (a >> 8);
    if (bpp == 0) begin
      rgb = {4'((d & 7) << 1), 4'(((d >> 3) & 7) << 1), 4'(((d >> 6) & 3) << 2)};
    end else begin
      n   = 1 << bpp;
      w   = 8 >> bpp;
      sub = px % n;
      idx = (d >> ((n - 1 - sub) * w)) & ((1 << w) - 1);
      rgb = m_pal[idx];
    end
    return {16'(a), rgb};
  endfunction

  initial begin
    logic [27:0] res;
    int slot;
    for (int i = 0; i < 64; i++) begin
      h_rst[i] = 1'b1;
      h_val[i] = '0;
    end
    forever begin
      @(posedge clk);
      n_edge = n_edge + 1;
      slot = n_edge % 64;
      if (!reset) begin
        h_rst[slot]  = 1'b1;
        h_val[slot]  = '0;
        m_addr       = '0;
        started      = 1'b1;
        m_mode_sh    = '0;
        m_mode_act   = '0;
        m_base_sh    = '0;
        m_base_act   = '0;
        m_stride_sh  = 8'h80;
        m_stride_act = 8'h80;
        for (int i = 0; i < 16; i++) m_pal[i] = {4'(i), 4'(i), 4'(i)};
        m_pal_idx    = 0;
        m_stg        = '0;
        m_vs_prev    = 1'b0;
      end else begin
        res         = model_px(int'(column), int'(line));
        m_addr      = res[27:12];
        h_rst[slot] = 1'b0;
        h_val[slot] = {visible ? res[11:0] : 12'h000, hsync_in, vsync_in};
        if (!m_vs_prev && vsync_in) begin
          m_mode_act   = m_mode_sh;
          m_base_act   = m_base_sh;
          m_stride_act = m_stride_sh;
        end
        if (reg_we) begin
          case (reg_addr)
            3'd0: m_mode_sh = reg_data[5:0];
            3'd1: m_base_sh[7:0] = reg_data;
            3'd2: m_base_sh[15:8] = reg_data;
            3'd3: m_stride_sh = reg_data;
            3'd4: m_pal_idx = int'(reg_data[3:0]);
            3'd5: m_stg = reg_data;
            3'd6: begin
              m_pal[m_pal_idx] = {reg_data[3:0], m_stg};
              m_pal_idx = (m_pal_idx + 1) % 16;
            end
            default: ;
          endcase
        end
        m_vs_prev = vsync_in;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int lat;
    bit z;
    logic [13:0] e;
    if (!started) return;
    for (int k = 0; k < NI; k++) begin
      lat = k + 1;
      z = 1'b0;
      for (int j = 0; j <= lat + 1; j++)
        if (j >= n_edge || h_rst[(n_edge - j) % 64]) z = 1'b1;
      e = z ? 14'h0 : h_val[(n_edge - lat - 1) % 64];
      chk($sformatf("pix_L%0d", lat), 32'({o_r[k], o_g[k], o_b[k], o_hs[k], o_vs[k]}), 32'(e));
      chk($sformatf("addr_L%0d", lat), 32'(o_addr[k]), 32'(m_addr));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic chk_rgb(input string name, input logic [11:0] exp);
    for (int k = 0; k < NI; k++)
      chk($sformatf("%s_L%0d", name, k + 1), 32'({o_r[k], o_g[k], o_b[k]}), 32'(exp));
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    reg_we = 1'b1; reg_addr = a; reg_data = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    tick();
  endtask

  task automatic show(input int c, input int l, input string name, input logic [11:0] exp);
    column = 10'(c); line = 10'(l); visible = 1'b1;
    repeat (6) tick();
    chk_rgb(name, exp);
  endtask

  initial begin
    reset = 1'b0; column = '0; line = '0; visible = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    reg_we = 1'b0; reg_addr = '0; reg_data = '0;
    repeat (3) tick();
    chk("reset_addr", 32'(o_addr[0]), 32'h0);
    chk("reset_out", 32'({o_r[3], o_g[3], o_b[3], o_hs[3], o_vs[3]}), 32'h0);
    reset = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;

    // Default 8bpp, stride 0x80
    column = 10'd0; line = 10'd3; visible = 1'b1;
    tick();
    chk("addr_0180", 32'(o_addr[0]), 32'h0180);
    repeat (5) tick();
    chk_rgb("rgb332_81", 12'h208);
    show(5, 3, "rgb332_84", 12'h808);

    // 4bpp through the grey ramp
    visible = 1'b0;
    write_reg(3'd0, 8'h01);
    vsync_pulse();
    show(330, 0, "bpp4_hi", 12'hAAA);
    show(331, 0, "bpp4_lo", 12'h555);

    // 1bpp, palette[0]=black, palette[1]=red, byte 0x80 at BASE 0x0080
    visible = 1'b0;
    repeat (8) tick();
    write_reg(3'd4, 8'h00);
    write_reg(3'd5, 8'h00);
    write_reg(3'd6, 8'h00);
    write_reg(3'd5, 8'h00);
    write_reg(3'd6, 8'h0F);
    write_reg(3'd1, 8'h80);
    write_reg(3'd0, 8'h03);
    vsync_pulse();
    for (int c = 0; c < 8; c++) show(c, 0, $sformatf("bpp1_c%0d", c), (c == 0) ? 12'hF00 : 12'h000);

    // Scaling and address wrap, checked during blanking
    visible = 1'b0;
    write_reg(3'd0, 8'h14);
    write_reg(3'd1, 8'hF0);
    write_reg(3'd2, 8'hFF);
    write_reg(3'd3, 8'h10);
    vsync_pulse();
    column = 10'd6; line = 10'd2;
    tick();
    chk("addr_wrap", 32'(o_addr[0]), 32'h0003);

    // MODE write coinciding with the vsync edge waits a frame
    write_reg(3'd1, 8'h00);
    write_reg(3'd2, 8'h00);
    write_reg(3'd3, 8'h80);
    write_reg(3'd0, 8'h00);
    vsync_pulse();
    vsync_in = 1'b1; reg_we = 1'b1; reg_addr = 3'd0; reg_data = 8'h01;
    tick();
    reg_we = 1'b0; vsync_in = 1'b0;
    tick();
    show(330, 0, "same_cycle_old", 12'h624);
    vsync_pulse();
    show(330, 0, "same_cycle_new", 12'hAAA);

    // Reset mid-line
    hsync_in = 1'b1; column = 10'd100;
    repeat (6) tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < NI; k++)
      chk($sformatf("midreset_L%0d", k + 1), 32'({o_r[k], o_g[k], o_b[k], o_hs[k], o_vs[k]}), 32'h0);
    reset = 1'b1;
    repeat (6) tick();
    for (int k = 0; k < NI; k++) chk($sformatf("realign_hs_L%0d", k + 1), 32'(o_hs[k]), 32'h1);

    // Randomised frames
    for (int s = 0; s < 10; s++) begin
      visible = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; reset = 1'b1;
      repeat (8) tick();
      for (int p = 0; p < 4; p++) write_reg(3'(4 + $urandom_range(0, 2)), 8'($urandom));
      if (s == 3) begin
        write_reg(3'd3, 8'h00);
        vsync_pulse();
      end
      for (int c = 0; c < 300; c++) begin
        column   = 10'($urandom_range(0, 1023));
        line     = 10'($urandom_range(0, 1023));
        visible  = ($urandom_range(0, 3) != 0);
        hsync_in = ($urandom_range(0, 7) == 0);
        vsync_in = ($urandom_range(0, 15) == 0);
        reg_we   = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 4))
          0: reg_addr = 3'd0;
          1: reg_addr = 3'd1;
          2: reg_addr = 3'd2;
          3: reg_addr = 3'd3;
          default: reg_addr = 3'd7;
        endcase
        reg_data = 8'($urandom);
        reset    = ($urandom_range(0, 199) != 0);
        tick();
      end
      reg_we = 1'b0;
    end

    reset = 1'b1; visible = 1'b0;
    repeat (8) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
